// File: rtl/pe_array_sched_if.sv
// ---------------------------------------------------------------------------
// pe_array_sched_if
// Job-request, operand-handshake and PE-control bundle between a requester
// (master) and the PE array sequencing controller (slave).
//   start/cfg_len/cfg_vert/cfg_pass : job request, sampled when start && ready
//   in_valid / in_rdy               : operand beat handshake
//   ready                           : controller idle
//   in_en, active, pe_a..pe_h       : PE control lines for one broadcast group
//   done                            : one-cycle pulse, PE opsum holds result
// ---------------------------------------------------------------------------
interface pe_array_sched_if #(
    parameter int LEN_W = 8
) ();
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_vert;
    logic             cfg_pass;
    logic             in_valid;
    logic             ready;
    logic             in_rdy;
    logic             in_en;
    logic             active;
    logic             pe_a;
    logic             pe_b;
    logic             pe_c;
    logic             pe_d;
    logic             pe_e;
    logic             pe_h;
    logic             done;

    modport master (
        output start, cfg_len, cfg_vert, cfg_pass, in_valid,
        input  ready, in_rdy, in_en, active, pe_a, pe_b, pe_c, pe_d, pe_e, pe_h, done
    );

    modport slave (
        input  start, cfg_len, cfg_vert, cfg_pass, in_valid,
        output ready, in_rdy, in_en, active, pe_a, pe_b, pe_c, pe_d, pe_e, pe_h, done
    );
endinterface

// File: rtl/pe_array_sched.sv
// ---------------------------------------------------------------------------
// pe_array_sched
// Sequencing controller for a broadcast group of PEs. Accepts one
// accumulation job per start handshake, issues K operand beats (stalling on
// in_valid bubbles), then drains the two-stage PE pipeline so that the
// accumulation clear (pe_c) and output capture (pe_d) land on the beats they
// belong to, and finally pulses done when opsum holds the result.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active low
//   bus_io : pe_array_sched_if slave modport (job request, operand
//            handshake, PE control lines, done)
// in_en/pe_a/pe_b follow in_valid within the issue cycle, so they are a
// direct gate of in_valid by the registered issue-state flag; every other
// output is a register.
// ---------------------------------------------------------------------------
module pe_array_sched #(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    pe_array_sched_if.slave   bus_io
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Beat tag travelling alongside the operand/multiplier pipeline.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    localparam logic [LEN_W-1:0] CNT_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam tag_t             TAG_NONE = 3'b000;

    state_t           state_q,  state_d;
    logic [LEN_W-1:0] cnt_q,    cnt_d;
    logic             first_q,  first_d;
    logic             vert_q,   vert_d;
    logic             drain_q,  drain_d;
    tag_t             tag1_q,   tag1_d;
    tag_t             tag2_q,   tag2_d;
    logic             ready_q,  ready_d;
    logic             in_rdy_q, in_rdy_d;
    logic             active_q, active_d;
    logic             pe_c_q,   pe_c_d;
    logic             pe_d_q,   pe_d_d;
    logic             pe_e_q,   pe_e_d;
    logic             pe_h_q,   pe_h_d;
    logic             done_q,   done_d;

    logic             issue_s;
    logic             pipe_s;

    // A beat is consumed only while issuing and the source offers one.
    assign issue_s = in_rdy_q & bus_io.in_valid;

    // Next-state, beat counter, tag pipeline and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        vert_d  = vert_q;
        drain_d = drain_q;
        pe_e_d  = pe_e_q;
        tag1_d  = TAG_NONE;
        tag2_d  = TAG_NONE;

        case (state_q)
            ST_IDLE: begin
                if (bus_io.start) begin
                    vert_d  = bus_io.cfg_vert;
                    pe_e_d  = bus_io.cfg_pass;
                    cnt_d   = bus_io.cfg_len;
                    first_d = 1'b1;
                    drain_d = 1'b0;
                    if (bus_io.cfg_len != CNT_ZERO) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Bubbles push an invalid tag so stage alignment is preserved.
                tag1_d.vld   = issue_s;
                tag1_d.first = issue_s & first_q;
                tag1_d.last  = issue_s & (cnt_q == CNT_ONE);
                tag2_d       = tag1_q;
                if (issue_s) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    first_d = 1'b0;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                // Two cycles flush the last issued tag out of stage 2.
                tag1_d = TAG_NONE;
                tag2_d = tag1_q;
                if (drain_q) begin
                    state_d = ST_DONE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pipe_s   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        ready_d  = (state_d == ST_IDLE);
        in_rdy_d = (state_d == ST_ISSUE);
        active_d = pipe_s;
        done_d   = (state_d == ST_DONE);

        if (state_d == ST_ISSUE) begin
            pe_h_d = vert_d;
        end else begin
            pe_h_d = 1'b0;
        end

        // pe_c/pe_d for next cycle come from what will sit in stage 2.
        if (pipe_s) begin
            pe_c_d = ~(tag2_d.vld & tag2_d.first);
            pe_d_d = tag2_d.vld & tag2_d.last;
        end else begin
            pe_c_d = 1'b0;
            pe_d_d = 1'b0;
        end
    end

    // Controller state and registered PE control lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            first_q  <= 1'b0;
            vert_q   <= 1'b0;
            drain_q  <= 1'b0;
            tag1_q   <= TAG_NONE;
            tag2_q   <= TAG_NONE;
            ready_q  <= 1'b1;
            in_rdy_q <= 1'b0;
            active_q <= 1'b0;
            pe_c_q   <= 1'b0;
            pe_d_q   <= 1'b0;
            pe_e_q   <= 1'b0;
            pe_h_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            vert_q   <= vert_d;
            drain_q  <= drain_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            ready_q  <= ready_d;
            in_rdy_q <= in_rdy_d;
            active_q <= active_d;
            pe_c_q   <= pe_c_d;
            pe_d_q   <= pe_d_d;
            pe_e_q   <= pe_e_d;
            pe_h_q   <= pe_h_d;
            done_q   <= done_d;
        end
    end

    assign bus_io.ready  = ready_q;
    assign bus_io.in_rdy = in_rdy_q;
    assign bus_io.in_en  = issue_s;
    assign bus_io.pe_a   = issue_s;
    assign bus_io.pe_b   = issue_s;
    assign bus_io.active = active_q;
    assign bus_io.pe_c   = pe_c_q;
    assign bus_io.pe_d   = pe_d_q;
    assign bus_io.pe_e   = pe_e_q;
    assign bus_io.pe_h   = pe_h_q;
    assign bus_io.done   = done_q;

endmodule

// File: tb/tb_pe_array_sched.sv
// ---------------------------------------------------------------------------
// tb_pe_array_sched
// Directed bench for pe_array_sched. Each stimulus cycle pushes the
// hand-derived control-line vector for that cycle into a queue; a monitor on
// the falling edge pops and compares. A small behavioural PE driven by the
// control lines accumulates a*b; at every done pulse the monitor compares its
// opsum with the hand-computed sum queued when the job was started.
// Vector bit order: ready in_rdy in_en active pe_a pe_b pe_c pe_d pe_e pe_h done
// ---------------------------------------------------------------------------
module tb_pe_array_sched;

    logic clk;
    logic rst;
    logic [7:0] a_data;
    logic [7:0] b_data;

    int n_cmp;
    int n_err;
    int cyc;

    logic [10:0] exp_q[$];
    int          sum_q[$];

    pe_array_sched_if #(.LEN_W(8)) bus_if ();

    pe_array_sched #(.LEN_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE: operand regs, multiplier reg, accumulator, opsum.
    logic [7:0]  opa, opb;
    logic [15:0] prod;
    logic [23:0] acc, opsum;
    always @(posedge clk) begin
        opa  <= (bus_if.in_en && bus_if.pe_a) ? a_data : 8'd0;
        opb  <= (bus_if.in_en && bus_if.pe_b) ? b_data : 8'd0;
        prod <= opa * opb;
        acc  <= bus_if.pe_c ? (acc + 24'(prod)) : 24'(prod);
        if (bus_if.pe_d) opsum <= bus_if.pe_c ? (acc + 24'(prod)) : 24'(prod);
    end

    logic [10:0] obs;
    assign obs = {bus_if.ready, bus_if.in_rdy, bus_if.in_en, bus_if.active,
                  bus_if.pe_a, bus_if.pe_b, bus_if.pe_c, bus_if.pe_d,
                  bus_if.pe_e, bus_if.pe_h, bus_if.done};

    // Monitor: compare control lines each expected cycle, opsum on done.
    always @(negedge clk) begin
        logic [10:0] e;
        int          s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL ctrl cycle %0d: got %b expected %b", cyc, obs, e);
            end
        end
        if (bus_if.done === 1'b1) begin
            n_cmp++;
            if (sum_q.size() == 0) begin
                n_err++;
                $display("FAIL done cycle %0d: got unexpected done, expected none", cyc);
            end else begin
                s = sum_q.pop_front();
                if (s >= 0 && opsum !== 24'(s)) begin
                    n_err++;
                    $display("FAIL opsum cycle %0d: got %0d expected %0d", cyc, opsum, s);
                end
            end
        end
    end

    // One cycle of stimulus plus its expected control-line vector.
    task automatic step(input logic r, input logic st, input logic [7:0] len,
                        input logic vt, input logic ps, input logic iv,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [10:0] e);
        rst             = r;
        bus_if.start    = st;
        bus_if.cfg_len  = len;
        bus_if.cfg_vert = vt;
        bus_if.cfg_pass = ps;
        bus_if.in_valid = iv;
        a_data          = a;
        b_data          = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst             = 1'b0;
        bus_if.start    = 1'b1;
        bus_if.cfg_len  = 8'd4;
        bus_if.cfg_vert = 1'b0;
        bus_if.cfg_pass = 1'b0;
        bus_if.in_valid = 1'b0;
        a_data = 8'd0;
        b_data = 8'd0;
        @(posedge clk);
        #1;

        // Reset held with start high: only ready.
        step(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 11'b10000000000);
        step(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 11'b10000000000);

        // K=4, no bubbles: sum 1*2+3*4+5*6+7*8 = 100.
        sum_q.push_back(100);
        step(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 11'b01111110000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd4, 11'b01111110000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd5, 8'd6, 11'b01111100000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd7, 8'd8, 11'b01111110000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 11'b00010010000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 11'b00010011000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00000000001);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);

        // K=3, in_valid 1,0,1,0,1: sum 2*3+4*5+6*7 = 68.
        sum_q.push_back(68);
        step(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd3, 11'b01111110000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd9, 11'b01010010000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd4, 8'd5, 11'b01111100000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd9, 8'd9, 11'b01010010000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd6, 8'd7, 11'b01111110000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00010010000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00010011000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00000000001);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);

        // K=1, vert=1, pass=1: sum 5*5 = 25; pe_e stays high afterwards.
        sum_q.push_back(25);
        step(1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 11'b10000000000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd5, 8'd5, 11'b01111110110);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00010010100);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00010001100);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00000000101);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000100);

        // K=0 (done in cycle 1), then K=2 accepted in cycle 2 with start
        // held during ISSUE (ignored): sum 1*1+2*3 = 7.
        sum_q.push_back(-1);
        step(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 11'b10000000100);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 11'b00000000001);
        sum_q.push_back(7);
        step(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);
        step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 11'b01111110000);
        step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 8'd2, 8'd3, 11'b01111110000);
        step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 11'b00010000000);
        step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 11'b00010011000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b00000000001);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);

        // K=8, vert=1, pass=1, reset pulsed low in cycle 5: no done.
        step(1'b1, 1'b1, 8'd8, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 11'b10000000000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 11'b01111110110);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 11'b01111110110);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 11'b01111100110);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 11'b01111110110);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 11'b10000000000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 11'b10000000000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 11'b10000000000);

        // Let the monitor consume the last vector, then check nothing is left.
        @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0 || sum_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d ctrl / %0d sum entries left, expected 0 / 0",
                     exp_q.size(), sum_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
